// File: rtl/seg7_multi_display_if.sv
// seg7_multi_display_if: Avalon-MM slave bus for the multi-digit seven-segment display
interface seg7_multi_display_if;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    modport master(output address, chipselect, write_n, writedata, input readdata);
    modport slave(input address, chipselect, write_n, writedata, output readdata);
endinterface

// File: rtl/seg7_multi_display.sv
// seg7_multi_display: Avalon-MM driven NUM_DIGITS hex display with enable/blink masks
// Optional decimal points per digit when SEG7_DP_EN is defined (digit width 8 instead of 7).
module seg7_multi_display #(
    parameter int NUM_DIGITS = 6,
    parameter int BLINK_DIV  = 25000000,
    parameter bit ACTIVE_LOW = 1,
`ifdef SEG7_DP_EN
    localparam int SW = 8
`else
    localparam int SW = 7
`endif
) (
    input  logic                     clk,
    input  logic                     reset,
    seg7_multi_display_if.slave      bus,
    output logic [NUM_DIGITS*SW-1:0] hex_out
);
    localparam int CW = $clog2(BLINK_DIV);
    localparam logic [CW-1:0] LAST = CW'(BLINK_DIV - 1);
    localparam logic [6:0] SEG [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    logic [4*NUM_DIGITS-1:0] data;
    logic [NUM_DIGITS-1:0]   en;
    logic [NUM_DIGITS-1:0]   blink;
    logic [CW-1:0]           cnt;
    logic                    phase;
    logic [NUM_DIGITS*SW-1:0] hex_next;
    logic [31:0]             dp_rd;
    logic                    wr;
    assign wr = bus.chipselect & ~bus.write_n;
`ifdef SEG7_DP_EN
    logic [NUM_DIGITS-1:0] dp;
    assign dp_rd = 32'(dp);
    always_ff @(posedge clk)
        if (reset)
            dp <= '0;
        else if (wr && bus.address == 2'd3)
            dp <= bus.writedata[NUM_DIGITS-1:0];
`else
    assign dp_rd = '0;
`endif
    assign bus.readdata = bus.address == 2'd0 ? 32'(data) :
                          bus.address == 2'd1 ? 32'(en) :
                          bus.address == 2'd2 ? 32'(blink) : dp_rd;
    for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_dig
        logic lit;
        logic [SW-1:0] seg;
        assign lit = en[i] & ~(blink[i] & phase);
`ifdef SEG7_DP_EN
        assign seg = {dp[i] & lit, lit ? SEG[data[4*i+:4]] : 7'h00};
`else
        assign seg = lit ? SEG[data[4*i+:4]] : 7'h00;
`endif
        assign hex_next[SW*i+:SW] = ACTIVE_LOW ? ~seg : seg;
    end
    // A BLINK write restarts the prescaler so newly blinking digits begin visible
    always_ff @(posedge clk)
        if (reset) begin
            data    <= '0;
            en      <= '1;
            blink   <= '0;
            cnt     <= '0;
            phase   <= 1'b0;
            hex_out <= ACTIVE_LOW ? '1 : '0;
        end else begin
            if (wr && bus.address == 2'd0) data <= bus.writedata[4*NUM_DIGITS-1:0];
            if (wr && bus.address == 2'd1) en <= bus.writedata[NUM_DIGITS-1:0];
            if (wr && bus.address == 2'd2) begin
                blink <= bus.writedata[NUM_DIGITS-1:0];
                cnt   <= '0;
                phase <= 1'b0;
            end else if (cnt == LAST) begin
                cnt   <= '0;
                phase <= ~phase;
            end else
                cnt <= cnt + CW'(1);
            hex_out <= hex_next;
        end
endmodule
